// File: rtl/masked_sbox_scheduler_pkg.sv
// Shared definitions for the masked S-box scheduler: FSM encoding, S-box
// latency, byte count and the in-flight tag carried alongside the S-box.
// Build option: SCHED_KEYSCHED_EN widens the operation to 20 bytes
// (16 state bytes followed by 4 key-schedule bytes).
package masked_sched_pkg;

    localparam int SBOX_LAT = 3;

`ifdef SCHED_KEYSCHED_EN
    localparam int NBYTES = 20;
`else
    localparam int NBYTES = 16;
`endif

    localparam int NBITS = 8 * NBYTES;
    // Issue counter must be able to hold NBYTES itself.
    localparam int CNTW  = $clog2(NBYTES + 1);
    localparam int IDXW  = $clog2(NBYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One entry per S-box pipeline slot: which result byte it belongs to.
    typedef struct packed {
        logic            valid;
        logic [IDXW-1:0] idx;
    } tag_t;

endpackage

// File: rtl/masked_sbox_scheduler_tag_pipe.sv
// Tag shift register that runs in lockstep with the external S-box pipeline.
// A tag entering in cycle t appears on out_tag in cycle t+SBOX_LAT, the same
// cycle the matching S-box result is on sb_out0/sb_out1.
module sbox_tag_pipe
    import masked_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  tag_t in_tag,
    output tag_t out_tag
);

    tag_t stage [SBOX_LAT];

    // Shift tags one slot per cycle; reset drops every in-flight entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SBOX_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_tag;
            for (int i = 1; i < SBOX_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_tag = stage[SBOX_LAT-1];

endmodule

// File: rtl/masked_sbox_scheduler.sv
// Masked S-box scheduler: captures a two-share state, feeds one byte per
// cycle (plus 64 fresh random bits) to the external masked S-box, tracks
// bytes in flight and reassembles the shared SubBytes result.
// Shares are never combined here: results are the raw S-box output shares.
// Build option: SCHED_KEYSCHED_EN adds kin0/kin1/kout0/kout1 (4 key bytes
// issued after the 16 state bytes).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready/out_valid are registered; rnd_ready is combinational
// (asserted in ISSUE whenever rnd_valid is high) and means rnd_i is consumed
// in that cycle.
module masked_sbox_scheduler
    import masked_sched_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in0,
    input  logic [127:0]  in1,
`ifdef SCHED_KEYSCHED_EN
    input  logic [31:0]   kin0,
    input  logic [31:0]   kin1,
`endif
    input  logic [63:0]   rnd_i,
    input  logic          rnd_valid,
    output logic          rnd_ready,
    output logic [7:0]    sb_in0,
    output logic [7:0]    sb_in1,
    output logic [63:0]   sb_r,
    input  logic [7:0]    sb_out0,
    input  logic [7:0]    sb_out1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out0,
    output logic [127:0]  out1,
`ifdef SCHED_KEYSCHED_EN
    output logic [31:0]   kout0,
    output logic [31:0]   kout1,
`endif
    output state_t        dbg_state
);

    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic [NBITS-1:0] cap0;
    logic [NBITS-1:0] cap1;
    logic [NBITS-1:0] res0;
    logic [NBITS-1:0] res1;
    logic [NBITS-1:0] load0;
    logic [NBITS-1:0] load1;
    tag_t             issue_tag;
    tag_t             done_tag;
    logic             issue;
    logic             last_issue;
    logic             last_capture;

`ifdef SCHED_KEYSCHED_EN
    assign load0 = {kin0, in0};
    assign load1 = {kin1, in1};
`else
    assign load0 = in0;
    assign load1 = in1;
`endif

    assign issue        = (state == ST_ISSUE) && rnd_valid;
    assign last_issue   = issue && (cnt == CNTW'(NBYTES - 1));
    // Bytes retire in issue order, so the last index marks the final capture.
    assign last_capture = done_tag.valid && (done_tag.idx == IDXW'(NBYTES - 1));

    assign rnd_ready = issue;
    assign dbg_state = state;

    // S-box inputs carry data only on issuing cycles, zero otherwise.
    always_comb begin
        sb_in0          = 8'd0;
        sb_in1          = 8'd0;
        sb_r            = 64'd0;
        issue_tag.valid = issue;
        issue_tag.idx   = cnt[IDXW-1:0];
        if (issue) begin
            sb_in0 = cap0[8*int'(cnt) +: 8];
            sb_in1 = cap1[8*int'(cnt) +: 8];
            sb_r   = rnd_i;
        end
    end

    sbox_tag_pipe u_tag_pipe (
        .clk     (CLK),
        .rst_n   (RST_N),
        .in_tag  (issue_tag),
        .out_tag (done_tag)
    );

    // Operation sequencer: capture, issue, wait for the pipe, hand off.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap0      <= '0;
            cap1      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cap0     <= load0;
                        cap1     <= load1;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue) begin
                        cnt <= cnt + 1'b1;
                        if (last_issue) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_capture) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write each retiring S-box result into its byte slot of the result shares.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            res0 <= '0;
            res1 <= '0;
        end else if (done_tag.valid) begin
            res0[8*int'(done_tag.idx) +: 8] <= sb_out0;
            res1[8*int'(done_tag.idx) +: 8] <= sb_out1;
        end
    end

    assign out0 = res0[127:0];
    assign out1 = res1[127:0];
`ifdef SCHED_KEYSCHED_EN
    assign kout0 = res0[159:128];
    assign kout1 = res1[159:128];
`endif

endmodule

// File: tb/tb_masked_sbox_scheduler.sv
// Bench for masked_sbox_scheduler (default build, 16 bytes). A behavioural
// three-stage masked S-box sits on the sb_* ports; the driver issues
// operations and pushes expected results, a monitor pops and compares.
module tb_masked_sbox_scheduler;

    localparam int NB = 16;
    localparam int EW = 32 + 128 + 128;   // {valid cycle, share1, share xor}

    logic         CLK;
    logic         RST_N;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in0;
    logic [127:0] in1;
    logic [63:0]  rnd_i;
    logic         rnd_valid;
    logic         rnd_ready;
    logic [7:0]   sb_in0;
    logic [7:0]   sb_in1;
    logic [63:0]  sb_r;
    logic [7:0]   sb_out0;
    logic [7:0]   sb_out1;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out0;
    logic [127:0] out1;
    logic [1:0]   dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [EW-1:0] exp_q[$];
    logic [7:0]    sbox_t [256];

    masked_sbox_scheduler dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .rnd_i     (rnd_i),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .sb_in0    (sb_in0),
        .sb_in1    (sb_in1),
        .sb_r      (sb_r),
        .sb_out0   (sb_out0),
        .sb_out1   (sb_out1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- AES S-box reference ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'd0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'd1;
        logic [7:0] s;
        logic [7:0] r;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        s = inv;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [7:0] mask_of(input logic [63:0] r);
        return r[7:0] ^ r[63:56];
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) sbox_t[i] = aes_sbox(8'(i));
    end

    // Behavioural masked S-box: 3 cycles, share1 = mask from randomness.
    logic [7:0] p0 [3];
    logic [7:0] p1 [3];
    always @(posedge CLK) begin
        p0[0] <= sbox_t[sb_in0 ^ sb_in1] ^ mask_of(sb_r);
        p1[0] <= mask_of(sb_r);
        p0[1] <= p0[0];
        p1[1] <= p1[0];
        p0[2] <= p0[1];
        p1[2] <= p1[1];
    end
    assign sb_out0 = p0[2];
    assign sb_out1 = p1[2];

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input logic [127:0] a, input logic [127:0] b, input int mode,
                          input bit do_reset, input bit use_lit, input logic [127:0] lit);
        logic [127:0] ex_x;
        logic [127:0] ex_s1;
        int           acc;
        int           tries;
        int           n;
        int           bub;
        int           gap;
        bit           v;
        for (int i = 0; i < NB; i++) ex_x[8*i +: 8] = sbox_t[a[8*i +: 8] ^ b[8*i +: 8]];
        if (use_lit) ex_x = lit;
        in0      = a;
        in1      = b;
        in_valid = 1'b1;
        tries    = 0;
        while (!in_ready && tries < 300) begin
            @(posedge CLK); #1;
            tries++;
        end
        if (!in_ready) begin
            check("accept_timeout", {127'd0, in_ready}, 128'd1);
            in_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        in0      = {$urandom, $urandom, $urandom, $urandom};
        in1      = {$urandom, $urandom, $urandom, $urandom};
        n   = 0;
        bub = 0;
        gap = 0;
        while (n < NB) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 3) != 0);
                default: v = !(n == 5 && gap < 3);
            endcase
            rnd_valid = v;
            rnd_i     = {$urandom, $urandom};
            if (v) begin
                ex_s1[8*n +: 8] = mask_of(rnd_i);
                n++;
            end else begin
                bub++;
                if (n == 5) gap++;
            end
            @(posedge CLK); #1;
        end
        rnd_valid = 1'($urandom_range(0, 1));
        rnd_i     = {$urandom, $urandom};
        if (do_reset) begin
            RST_N = 1'b0;
            @(posedge CLK); #1;
            RST_N = 1'b1;
        end else begin
            exp_q.push_back({32'(acc + 20 + bub), ex_s1, ex_x});
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [EW-1:0] cur;
    bit            busy       = 1'b0;
    bit            ho_pending = 1'b0;
    int            hold       = 0;
    int            rr_cnt     = 0;
    int            items      = 0;

    initial begin : monitor
        out_ready = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                busy       = 1'b0;
                ho_pending = 1'b0;
                rr_cnt     = 0;
                out_ready  = 1'b0;
                check("rst_in_ready", {127'd0, in_ready}, 128'd1);
                check("rst_out_valid", {127'd0, out_valid}, 128'd0);
                check("rst_rnd_ready", {127'd0, rnd_ready}, 128'd0);
                check("rst_sb_zero", {48'd0, sb_in0, sb_in1, sb_r}, 128'd0);
                check("rst_out0", out0, 128'd0);
                check("rst_out1", out1, 128'd0);
                continue;
            end
            if (rnd_ready) rr_cnt++;
            else check("sb_idle_zero", {48'd0, sb_in0, sb_in1, sb_r}, 128'd0);
            if (ho_pending) begin
                check("out_valid_after_hs", {127'd0, out_valid}, 128'd0);
                check("in_ready_after_hs", {127'd0, in_ready}, 128'd1);
                ho_pending = 1'b0;
                out_ready  = 1'b0;
            end else if (out_valid) begin
                if (!busy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out_valid", {127'd0, out_valid}, 128'd0);
                        out_ready  = 1'b1;
                        ho_pending = 1'b1;
                    end else begin
                        cur  = exp_q.pop_front();
                        busy = 1'b1;
                        check("latency", 128'(cyc), 128'(cur[287:256]));
                        check("rnd_ready_count", 128'(rr_cnt), 128'(NB));
                        rr_cnt = 0;
                        hold   = (items < 2) ? 5 : $urandom_range(0, 3);
                        items++;
                    end
                end
                if (busy) begin
                    check("subbytes_xor", out0 ^ out1, cur[127:0]);
                    check("share1", out1, cur[255:128]);
                    check("in_ready_in_done", {127'd0, in_ready}, 128'd0);
                    if (hold == 0) begin
                        out_ready  = 1'b1;
                        ho_pending = 1'b1;
                        busy       = 1'b0;
                    end else begin
                        hold--;
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (80000) @(posedge CLK);
        $display("FAIL watchdog: got cycle %0d required completion earlier", cyc);
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int w;
        RST_N     = 1'b0;
        in_valid  = 1'b0;
        in0       = '0;
        in1       = '0;
        rnd_i     = '0;
        rnd_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Idle after reset: nothing changes while in_valid stays low.
        for (int i = 0; i < 4; i++) begin
            rnd_valid = 1'b1;
            rnd_i     = {$urandom, $urandom};
            @(posedge CLK); #1;
            check("idle_in_ready", {127'd0, in_ready}, 128'd1);
            check("idle_out_valid", {127'd0, out_valid}, 128'd0);
            check("idle_rnd_ready", {127'd0, rnd_ready}, 128'd0);
            check("idle_out0", out0, 128'd0);
        end

        // Unshared counting state against known AES SubBytes values.
        run_op(128'h0f0e0d0c0b0a09080706050403020100, 128'd0, 0, 1'b0, 1'b1,
               128'h76abd7fe2b670130c56f6bf27b777c63);
        // Exactly three bubbles mid-issue.
        run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               2, 1'b0, 1'b0, 128'd0);
        // Random masked states with random randomness gaps.
        for (int k = 0; k < 256; k++) begin
            run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                   $urandom_range(0, 1), 1'b0, 1'b0, 128'd0);
        end
        // Reset pulsed during drain, then a normal operation.
        run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               0, 1'b1, 1'b0, 128'd0);
        run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               0, 1'b0, 1'b0, 128'd0);

        w = 0;
        while ((exp_q.size() != 0 || busy || ho_pending) && w < 300) begin
            @(posedge CLK); #1;
            w++;
        end
        check("drain_pending", 128'(exp_q.size()), 128'd0);
        repeat (2) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
